mem_store_ctrl: RTL and testbench

Write-side companion to the instruction-fetch memory controller: accepts one store request from the MEM stage (byte, half or word), serializes it into little-endian byte writes on the shared 8-bit RAM port, and signals completion. Sits between the MEM stage and the RAM bus arbiter. It requests the bus, holds it for the whole store, and releases it when done.

---
 rtl/mem_store_ctrl_pkg.sv | 35 +++
 rtl/mem_store_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_store_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_store_ctrl_pkg.sv
// Shared types and helpers for the store-side RAM port controller:
// state encoding, store width codes and byte-count/alignment helpers.
package mem_store_ctrl_pkg;

    localparam int MEM_ADDR_BUS_W = 32;

    localparam logic [1:0] ST_BYTE = 2'b00;
    localparam logic [1:0] ST_HALF = 2'b01;
    localparam logic [1:0] ST_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Index of the final byte lane for a width code; 2'b11 behaves as a word.
    function automatic logic [1:0] last_lane(input logic [1:0] width);
        case (width)
            ST_BYTE: return 2'd0;
            ST_HALF: return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
        case (width)
            ST_BYTE: return 1'b0;
            ST_HALF: return addr_lo[0];
            default: return |addr_lo;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_ctrl.sv
// Serializes one byte/half/word store into little-endian byte writes on the
// shared 8-bit RAM port. Optional reject of misaligned stores: STORE_ALIGN_CHECK_EN.
module mem_store_ctrl
    import mem_store_ctrl_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_width,
    output logic              st_busy,
    output logic              st_done,
    output logic              st_misalign,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        idx_q, idx_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bus_req_q, bus_req_d;
    logic              mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
`ifdef STORE_ALIGN_CHECK_EN
    logic              mis_q, mis_d;
`endif

    logic [1:0]        lane;
    logic [7:0]        lane_byte;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        data_d      = data_q;
        last_d      = last_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bus_req_d   = bus_req_q;
        mem_wr_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef STORE_ALIGN_CHECK_EN
        mis_d       = 1'b0;
`endif

        // Lane that goes on the bus next: byte 0 on grant, then one per edge.
        lane = (state_q == S_WRITE) ? idx_q + 2'd1 : 2'd0;
        case (lane)
            2'd0:    lane_byte = data_q[7:0];
            2'd1:    lane_byte = data_q[15:8];
            2'd2:    lane_byte = data_q[23:16];
            default: lane_byte = data_q[31:24];
        endcase

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d   = S_IDLE;
                busy_d    = 1'b0;
                bus_req_d = 1'b0;
                if (st_req) begin
                    base_d = st_addr;
                    data_d = st_data;
                    last_d = last_lane(st_width);
`ifdef STORE_ALIGN_CHECK_EN
                    if (misaligned(st_width, st_addr[1:0])) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
`else
                    begin
`endif
                        state_d   = S_REQ;
                        busy_d    = 1'b1;
                        bus_req_d = 1'b1;
                        idx_d     = 2'd0;
                    end
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    state_d     = S_WRITE;
                    idx_d       = 2'd0;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = base_q + {{(ADDR_W-2){1'b0}}, lane};
                    mem_wdata_d = lane_byte;
                end
            end
            S_WRITE: begin
                // Grant is no longer looked at: the bus is held until DONE.
                if (idx_q == last_q) begin
                    state_d   = S_DONE;
                    busy_d    = 1'b0;
                    bus_req_d = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    idx_d       = lane;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = base_q + {{(ADDR_W-2){1'b0}}, lane};
                    mem_wdata_d = lane_byte;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            data_q      <= '0;
            last_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bus_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            data_q      <= data_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bus_req_q   <= bus_req_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef STORE_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mis_q <= 1'b0;
        else      mis_q <= mis_d;
    end
    assign st_misalign = mis_q;
`else
    assign st_misalign = 1'b0;
`endif

    assign st_busy   = busy_q;
    assign st_done   = done_q;
    assign bus_req   = bus_req_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_store_ctrl.sv
// Self-checking bench for mem_store_ctrl: directed table, corner sequences
// and random stores compared against a transaction-level expectation model.
module tb_mem_store_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        st_req = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [1:0]  st_width = '0;
    logic        st_busy, st_done, st_misalign, bus_req, bus_gnt, mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;

    mem_store_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .st_req(st_req), .st_addr(st_addr),
        .st_data(st_data), .st_width(st_width), .st_busy(st_busy),
        .st_done(st_done), .st_misalign(st_misalign), .bus_req(bus_req),
        .bus_gnt(bus_gnt), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Arbiter: grants gnt_delay cycles after bus_req rises, or always when tied.
    int gnt_delay = 0;
    logic gnt_tie = 1'b0;
    int req_cycles = 0;
    always @(posedge clk) req_cycles <= bus_req ? req_cycles + 1 : 0;
    assign bus_gnt = gnt_tie | (bus_req && (req_cycles >= gnt_delay));

    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;
    wr_t  wr_q[$], exp_wr_q[$];
    int   done_q[$], exp_done_q[$];
    logic mis_q[$], exp_mis_q[$];
    int   bus_req_cnt = 0;

    // RAM: a write is committed only if the rising edge arrives while out of reset.
    logic        pend_vld = 1'b0;
    wr_t         pend;
    always @(negedge clk or negedge rst) begin
        if (!rst) pend_vld = 1'b0;
        else begin
            pend_vld = mem_wr;
            pend = '{mem_addr, mem_wdata, cyc};
        end
    end
    always @(posedge clk) begin
        if (pend_vld && rst) wr_q.push_back(pend);
        pend_vld = 1'b0;
    end
    always @(negedge clk) begin
        if (st_done) begin
            done_q.push_back(cyc);
            mis_q.push_back(st_misalign);
        end
        if (bus_req) bus_req_cnt++;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic model_misaligned(input logic [31:0] a, input logic [1:0] w);
`ifdef STORE_ALIGN_CHECK_EN
        if (w == 2'd0) return 1'b0;
        if (w == 2'd1) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // Expected behaviour of one accepted store whose request edge left cyc == c0.
    function automatic void add_expected(input int c0, input logic [31:0] a,
                                         input logic [31:0] d, input logic [1:0] w,
                                         input int dly);
        int n;
        n = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
        if (model_misaligned(a, w)) begin
            exp_done_q.push_back(c0 + 1);
            exp_mis_q.push_back(1'b1);
            return;
        end
        for (int i = 0; i < n; i++)
            exp_wr_q.push_back('{a + i, d[8*i +: 8], c0 + 1 + dly + i});
        exp_done_q.push_back(c0 + 1 + dly + n);
        exp_mis_q.push_back(1'b0);
    endfunction

    task automatic check_all();
        chk("write_count", wr_q.size(), exp_wr_q.size());
        for (int i = 0; i < wr_q.size() && i < exp_wr_q.size(); i++) begin
            chk($sformatf("wr%0d_addr", i), wr_q[i].addr, exp_wr_q[i].addr);
            chk($sformatf("wr%0d_data", i), wr_q[i].data, exp_wr_q[i].data);
            chk($sformatf("wr%0d_cycle", i), wr_q[i].cyc, exp_wr_q[i].cyc);
        end
        chk("done_count", done_q.size(), exp_done_q.size());
        for (int i = 0; i < done_q.size() && i < exp_done_q.size(); i++) begin
            chk($sformatf("done%0d_cycle", i), done_q[i], exp_done_q[i]);
            chk($sformatf("done%0d_misalign", i), mis_q[i], exp_mis_q[i]);
        end
        wr_q.delete(); exp_wr_q.delete();
        done_q.delete(); exp_done_q.delete();
        mis_q.delete(); exp_mis_q.delete();
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                         output int c0);
        st_addr = a; st_data = d; st_width = w; st_req = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        st_req = 1'b0;
    endtask

    task automatic wait_done(input int count);
        int k = 0;
        while (done_q.size() < count && k < 60) begin
            @(negedge clk); #1;
            k++;
        end
        chk("done_within_budget", done_q.size() >= count, 1'b1);
        chk("done_cycle_bus_req", bus_req, 1'b0);
        chk("done_cycle_busy", st_busy, 1'b0);
        chk("done_cycle_mem_wr", mem_wr, 1'b0);
        @(negedge clk); #1;
        chk("done_one_cycle", st_done, 1'b0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w,
                            input int dly, input logic tie);
        int c0;
        gnt_delay = dly; gnt_tie = tie;
        issue(a, d, w, c0);
        add_expected(c0, a, d, w, dly);
        wait_done(1);
        gnt_tie = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr; logic [31:0] data; logic [1:0] width; int dly; logic tie;
        int exp_n; logic [31:0] exp_a0; logic [7:0] exp_b0;
        logic [31:0] exp_an; logic [7:0] exp_bn;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c0, c1;
        tbl[0] = '{32'h100, 32'hDEADBEEF, 2'd2, 0, 1'b1, 4, 32'h100, 8'hEF, 32'h103, 8'hDE};
        tbl[1] = '{32'h7, 32'h000000A5, 2'd0, 3, 1'b0, 1, 32'h7, 8'hA5, 32'h7, 8'hA5};
        tbl[2] = '{32'hFFFFFFFF, 32'h00001234, 2'd1, 0, 1'b0, 2, 32'hFFFFFFFF, 8'h34, 32'h0, 8'h12};
        tbl[3] = '{32'h20, 32'h11223344, 2'd3, 1, 1'b0, 4, 32'h20, 8'h44, 32'h23, 8'h11};
        tbl[4] = '{32'hFFFFFFFE, 32'h0000BEEF, 2'd1, 2, 1'b0, 2, 32'hFFFFFFFE, 8'hEF, 32'hFFFFFFFF, 8'hBE};
        tbl[5] = '{32'hFFFFFFFD, 32'h01020304, 2'd2, 0, 1'b0, 4, 32'hFFFFFFFD, 8'h04, 32'h0, 8'h01};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", st_busy, 1'b0);
        chk("rst_done", st_done, 1'b0);
        chk("rst_misalign", st_misalign, 1'b0);
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_mem_wr", mem_wr, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 8'h0);
        rst = 1'b1;
        @(negedge clk); #1;

        // Directed table
        for (int t = 0; t < 6; t++) begin
            do_store(tbl[t].addr, tbl[t].data, tbl[t].width, tbl[t].dly, tbl[t].tie);
            if (!model_misaligned(tbl[t].addr, tbl[t].width)) begin
                chk($sformatf("tbl%0d_n", t), wr_q.size(), tbl[t].exp_n);
                if (wr_q.size() == tbl[t].exp_n) begin
                    chk($sformatf("tbl%0d_a0", t), wr_q[0].addr, tbl[t].exp_a0);
                    chk($sformatf("tbl%0d_b0", t), wr_q[0].data, tbl[t].exp_b0);
                    chk($sformatf("tbl%0d_an", t), wr_q[tbl[t].exp_n-1].addr, tbl[t].exp_an);
                    chk($sformatf("tbl%0d_bn", t), wr_q[tbl[t].exp_n-1].data, tbl[t].exp_bn);
                end
            end
            check_all();
        end

`ifdef STORE_ALIGN_CHECK_EN
        begin
            int before;
            before = bus_req_cnt;
            do_store(32'h102, 32'hCAFEBABE, 2'd2, 0, 1'b0);
            chk("misalign_no_bus_req", bus_req_cnt, before);
            check_all();
        end
`endif

        // Reset during the third byte of a word store
        gnt_delay = 0;
        issue(32'h200, 32'hCAFEF00D, 2'd2, c0);
        while (cyc < c0 + 3) begin @(negedge clk); #1; end
        rst = 1'b0;
        #1;
        chk("midrst_busy", st_busy, 1'b0);
        chk("midrst_bus_req", bus_req, 1'b0);
        chk("midrst_mem_wr", mem_wr, 1'b0);
        chk("midrst_mem_addr", mem_addr, 32'h0);
        chk("midrst_mem_wdata", mem_wdata, 8'h0);
        exp_wr_q.push_back('{32'h200, 8'h0D, c0 + 1});
        exp_wr_q.push_back('{32'h201, 8'hF0, c0 + 2});
        repeat (4) @(negedge clk);
        #1;
        check_all();
        rst = 1'b1;
        @(negedge clk); #1;
        do_store(32'h40, 32'h0000003C, 2'd0, 1, 1'b0);
        check_all();

        // Back-to-back acceptance from DONE, and a drop while busy
        gnt_delay = 0;
        issue(32'h300, 32'h87654321, 2'd2, c0);
        add_expected(c0, 32'h300, 32'h87654321, 2'd2, 0);
        while (cyc < c0 + 2) begin @(negedge clk); #1; end
        issue(32'h900, 32'h00000099, 2'd0, c1);
        while (cyc < c0 + 5) begin @(negedge clk); #1; end
        chk("b2b_done_cycle", st_done, 1'b1);
        issue(32'h400, 32'h0000005A, 2'd0, c1);
        chk("b2b_accept_cycle", c1, c0 + 6);
        add_expected(c1, 32'h400, 32'h0000005A, 2'd0, 0);
        wait_done(2);
        check_all();

        // Random stores
        for (int r = 0; r < 40; r++) begin
            logic [31:0] a, d;
            logic [1:0]  w;
            int          dly, gap;
            w   = 2'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3)) : $urandom;
            d   = $urandom;
            dly = $urandom_range(0, 4);
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(negedge clk); #1; end
            do_store(a, d, w, dly, 1'b0);
            check_all();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
